prng_lfsr: RTL and testbench

PRNG_LFSR -- requirements
Module: prng_lfsr

---
 rtl/prng_lfsr_pkg.sv | 18 +
 rtl/prng_lfsr.sv | 52 +++++
 tb/tb_prng_lfsr.sv | 120 ++++++++++++
 3 files changed

// File: rtl/prng_lfsr_pkg.sv
// Shared constants and the feedback helper for the XNOR-form Fibonacci LFSR.
package prng_lfsr_pkg;

    // Widest state the helper accepts; narrower states are zero-extended,
    // which leaves the parity of (state & taps) unchanged.
    localparam int unsigned LFSR_MAX_BITS = 64;

    localparam int unsigned DEF_STATE_BITS  = 4;
    localparam int unsigned DEF_OUTPUT_BITS = 2;

    function automatic logic tap_xnor(
        input logic [LFSR_MAX_BITS-1:0] step_in,
        input logic [LFSR_MAX_BITS-1:0] taps
    );
        return ~^(step_in & taps);
    endfunction

endpackage

// File: rtl/prng_lfsr.sv
// XNOR-form LFSR producing OUTPUT_BITS random bits per clock, entropy mixed into step 0.
// Latency: one register; no handshake, a fresh value every clock.
module prng_lfsr
    import prng_lfsr_pkg::*;
#(
    parameter int unsigned           STATE_BITS  = DEF_STATE_BITS,
    parameter logic [STATE_BITS-1:0] POLYNOMIAL  = 4'b1100,
    parameter logic [STATE_BITS-1:0] STATE_INIT  = 4'b0000,
    parameter int unsigned           OUTPUT_BITS = DEF_OUTPUT_BITS
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   entropy,
    output logic [OUTPUT_BITS-1:0] random
);

    logic [STATE_BITS-1:0] state;
    logic [STATE_BITS-1:0] state_next;

    for (genvar i = 0; i < OUTPUT_BITS; i++) begin : g_shift
        logic [STATE_BITS-1:0] step_in;
        logic                  fb;
        logic [STATE_BITS-1:0] new_state;

        // Only the first step of each clock sees the external entropy bit.
        if (i == 0) begin : g_first
            assign step_in = state;
            assign fb      = tap_xnor(LFSR_MAX_BITS'(step_in),
                                      LFSR_MAX_BITS'(POLYNOMIAL)) ^ entropy;
        end else begin : g_next
            assign step_in = g_shift[i-1].new_state;
            assign fb      = tap_xnor(LFSR_MAX_BITS'(step_in),
                                      LFSR_MAX_BITS'(POLYNOMIAL));
        end

        assign new_state = {step_in[STATE_BITS-2:0], fb};
    end

    assign state_next = g_shift[OUTPUT_BITS-1].new_state;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= STATE_INIT;
        end else begin
            state <= state_next;
        end
    end

    // Low bits hold the newest feedback bits, bit 0 being the most recent.
    assign random = state[OUTPUT_BITS-1:0];

endmodule

// File: tb/tb_prng_lfsr.sv
// Directed self-checking bench for prng_lfsr with hand-computed sequences.
module tb_prng_lfsr;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       entropy;
    logic [1:0] random;

    logic       rst_n_lk;
    logic       entropy_lk;
    logic [1:0] random_lk;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    prng_lfsr dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .entropy (entropy),
        .random  (random)
    );

    prng_lfsr #(
        .STATE_BITS  (4),
        .POLYNOMIAL  (4'b1100),
        .STATE_INIT  (4'b1111),
        .OUTPUT_BITS (2)
    ) dut_lk (
        .clk     (clk),
        .rst_n   (rst_n_lk),
        .entropy (entropy_lk),
        .random  (random_lk)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // State after each clock from 0000 with entropy=0 (two single steps per clock).
    logic [3:0] seq [15] = '{4'b0011, 4'b1110, 4'b1011, 4'b1100, 4'b0010,
                             4'b1010, 4'b1000, 4'b0001, 4'b0111, 4'b1101,
                             4'b0110, 4'b1001, 4'b0101, 4'b0100, 4'b0000};

    initial begin
        rst_n      = 1'b0;
        entropy    = 1'b0;
        rst_n_lk   = 1'b0;
        entropy_lk = 1'b0;

        step();
        step();
        check("reset_state",  32'(dut.state), 32'h0);
        check("reset_random", 32'(random),    32'h0);

        rst_n = 1'b1;
        #1;
        check("first_ns0", 32'(dut.g_shift[0].new_state), 32'b0001);
        check("first_ns1", 32'(dut.g_shift[1].new_state), 32'b0011);

        for (int k = 0; k < 15; k++) begin
            check("no_lockup_ns0", 32'(dut.g_shift[0].new_state == 4'hF), 32'h0);
            check("no_lockup_ns1", 32'(dut.g_shift[1].new_state == 4'hF), 32'h0);
            step();
            check("seq_state",  32'(dut.state), 32'(seq[k]));
            check("seq_random", 32'(random),    32'(seq[k][1:0]));
        end
        check("period_15", 32'(dut.state), 32'h0);

        entropy = 1'b1;
        #1;
        check("ent_ns0", 32'(dut.g_shift[0].new_state), 32'b0000);
        step();
        entropy = 1'b0;
        check("ent_state",  32'(dut.state), 32'b0001);
        check("ent_random", 32'(random),    32'b01);

        step();
        step();
        rst_n = 1'b0;
        entropy = 1'b1;
        step();
        check("midrst_state",  32'(dut.state), 32'h0);
        check("midrst_random", 32'(random),    32'h0);
        rst_n = 1'b1;
        entropy = 1'b0;
        for (int k = 0; k < 4; k++) begin
            step();
            check("restart_state",  32'(dut.state), 32'(seq[k]));
            check("restart_random", 32'(random),    32'(seq[k][1:0]));
        end

        check("lk_reset_state",  32'(dut_lk.state), 32'hF);
        check("lk_reset_random", 32'(random_lk),    32'h3);
        rst_n_lk = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            check("lk_stuck_state", 32'(dut_lk.state), 32'hF);
        end
        entropy_lk = 1'b1;
        step();
        entropy_lk = 1'b0;
        check("lk_escape_state",  32'(dut_lk.state), 32'b1101);
        check("lk_escape_random", 32'(random_lk),    32'b01);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
